// File: rtl/ex_forward_unit.sv
// Two-stage result pipeline behind the execution stage: bypasses S1/S2 results
// back to the operand muxes and presents S2 as the register-file write-back port.
module ex_forward_unit #(
    parameter int unsigned DATA_WIDTH     = 16,
    parameter int unsigned VECTOR_LENGTH  = 16,
    parameter int unsigned REG_ADDR_WIDTH = 4
) (
    input  logic                                  clk,
    input  logic                                  rst_n,
    input  logic                                  stall,
    input  logic                                  flush,
    input  logic                                  ex_valid,
    input  logic [1:0]                            ex_class,
    input  logic [REG_ADDR_WIDTH-1:0]             ex_rd,
    input  logic [DATA_WIDTH-1:0]                 ex_scalar,
    input  logic [DATA_WIDTH*VECTOR_LENGTH-1:0]   ex_vector,
    input  logic                                  dec_valid,
    input  logic [1:0]                            dec_class,
    input  logic [REG_ADDR_WIDTH-1:0]             dec_ra,
    input  logic [REG_ADDR_WIDTH-1:0]             dec_rb,
    output logic [DATA_WIDTH-1:0]                 A_ua_int,
    output logic [DATA_WIDTH-1:0]                 A_ua_fixed,
    output logic [DATA_WIDTH-1:0]                 B_ua_int,
    output logic [DATA_WIDTH-1:0]                 B_ua_fixed,
    output logic [DATA_WIDTH*VECTOR_LENGTH-1:0]   A_ua_vector,
    output logic [DATA_WIDTH*VECTOR_LENGTH-1:0]   B_ua_vector,
    output logic                                  s_mux_A,
    output logic                                  s_mux_B,
    output logic                                  wb_valid,
    output logic [1:0]                            wb_class,
    output logic [REG_ADDR_WIDTH-1:0]             wb_rd,
    output logic [DATA_WIDTH-1:0]                 wb_scalar,
    output logic [DATA_WIDTH*VECTOR_LENGTH-1:0]   wb_vector
);

    localparam int unsigned VEC_WIDTH  = DATA_WIDTH * VECTOR_LENGTH;
    localparam logic [1:0]  CLASS_INT  = 2'b00;
    localparam logic [1:0]  CLASS_NONE = 2'b11;

    logic                      s1_valid, s2_valid;
    logic [1:0]                s1_class, s2_class;
    logic [REG_ADDR_WIDTH-1:0] s1_rd, s2_rd;
    logic [DATA_WIDTH-1:0]     s1_scalar, s2_scalar;
    logic [VEC_WIDTH-1:0]      s1_vector, s2_vector;

    // Stage registers; flush clears the incoming S1 entry even while stalled.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_valid  <= 1'b0;
            s1_class  <= '0;
            s1_rd     <= '0;
            s1_scalar <= '0;
            s1_vector <= '0;
            s2_valid  <= 1'b0;
            s2_class  <= '0;
            s2_rd     <= '0;
            s2_scalar <= '0;
            s2_vector <= '0;
        end else if (stall) begin
            if (flush) begin
                s1_valid <= 1'b0;
            end
        end else begin
            s2_valid  <= s1_valid;
            s2_class  <= s1_class;
            s2_rd     <= s1_rd;
            s2_scalar <= s1_scalar;
            s2_vector <= s1_vector;
            s1_valid  <= ex_valid & (ex_class != CLASS_NONE) & ~flush;
            s1_class  <= ex_class;
            s1_rd     <= ex_rd;
            s1_scalar <= ex_scalar;
            s1_vector <= ex_vector;
        end
    end

    logic ok_a, ok_b;
    logic hit_s1_a, hit_s2_a, hit_s1_b, hit_s2_b;

    // Integer r0 is hard-wired and never forwarded.
    assign ok_a = dec_valid & ~((dec_class == CLASS_INT) && (dec_ra == '0));
    assign ok_b = dec_valid & ~((dec_class == CLASS_INT) && (dec_rb == '0));

    assign hit_s1_a = ok_a & s1_valid & (s1_class == dec_class) & (s1_rd == dec_ra);
    assign hit_s2_a = ok_a & s2_valid & (s2_class == dec_class) & (s2_rd == dec_ra);
    assign hit_s1_b = ok_b & s1_valid & (s1_class == dec_class) & (s1_rd == dec_rb);
    assign hit_s2_b = ok_b & s2_valid & (s2_class == dec_class) & (s2_rd == dec_rb);

    logic [DATA_WIDTH-1:0] a_scalar, b_scalar;
    logic [VEC_WIDTH-1:0]  a_vector, b_vector;

    // Operand select: S1 holds the younger result and wins over S2.
    always_comb begin
        a_scalar = '0;
        a_vector = '0;
        b_scalar = '0;
        b_vector = '0;
        if (hit_s1_a) begin
            a_scalar = s1_scalar;
            a_vector = s1_vector;
        end else if (hit_s2_a) begin
            a_scalar = s2_scalar;
            a_vector = s2_vector;
        end
        if (hit_s1_b) begin
            b_scalar = s1_scalar;
            b_vector = s1_vector;
        end else if (hit_s2_b) begin
            b_scalar = s2_scalar;
            b_vector = s2_vector;
        end
    end

    assign s_mux_A     = hit_s1_a | hit_s2_a;
    assign s_mux_B     = hit_s1_b | hit_s2_b;
    assign A_ua_int    = a_scalar;
    assign A_ua_fixed  = a_scalar;
    assign A_ua_vector = a_vector;
    assign B_ua_int    = b_scalar;
    assign B_ua_fixed  = b_scalar;
    assign B_ua_vector = b_vector;

    // Write-back is suppressed while stalled so a held S2 entry retires once.
    assign wb_valid  = s2_valid & ~stall;
    assign wb_class  = s2_valid ? s2_class  : '0;
    assign wb_rd     = s2_valid ? s2_rd     : '0;
    assign wb_scalar = s2_valid ? s2_scalar : '0;
    assign wb_vector = s2_valid ? s2_vector : '0;

endmodule

// File: tb/tb_ex_forward_unit.sv
// Directed bench for ex_forward_unit: forwarding, priority, filtering, stall/flush, reset.
module tb_ex_forward_unit;

    localparam int unsigned DW = 16;
    localparam int unsigned VL = 16;
    localparam int unsigned AW = 4;

    logic              clk = 1'b0;
    logic              rst_n, stall, flush, ex_valid, dec_valid;
    logic [1:0]        ex_class, dec_class;
    logic [AW-1:0]     ex_rd, dec_ra, dec_rb;
    logic [DW-1:0]     ex_scalar;
    logic [DW*VL-1:0]  ex_vector;
    logic [DW-1:0]     A_ua_int, A_ua_fixed, B_ua_int, B_ua_fixed, wb_scalar;
    logic [DW*VL-1:0]  A_ua_vector, B_ua_vector, wb_vector;
    logic              s_mux_A, s_mux_B, wb_valid;
    logic [1:0]        wb_class;
    logic [AW-1:0]     wb_rd;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    ex_forward_unit #(.DATA_WIDTH(DW), .VECTOR_LENGTH(VL), .REG_ADDR_WIDTH(AW)) dut (
        .clk(clk), .rst_n(rst_n), .stall(stall), .flush(flush),
        .ex_valid(ex_valid), .ex_class(ex_class), .ex_rd(ex_rd),
        .ex_scalar(ex_scalar), .ex_vector(ex_vector),
        .dec_valid(dec_valid), .dec_class(dec_class), .dec_ra(dec_ra), .dec_rb(dec_rb),
        .A_ua_int(A_ua_int), .A_ua_fixed(A_ua_fixed), .B_ua_int(B_ua_int), .B_ua_fixed(B_ua_fixed),
        .A_ua_vector(A_ua_vector), .B_ua_vector(B_ua_vector),
        .s_mux_A(s_mux_A), .s_mux_B(s_mux_B),
        .wb_valid(wb_valid), .wb_class(wb_class), .wb_rd(wb_rd),
        .wb_scalar(wb_scalar), .wb_vector(wb_vector)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_idle();
        stall = 1'b0; flush = 1'b0; ex_valid = 1'b0; ex_class = 2'b00; ex_rd = '0;
        ex_scalar = '0; ex_vector = '0; dec_valid = 1'b0; dec_class = 2'b00;
        dec_ra = '0; dec_rb = '0;
    endtask

    task automatic drain();
        set_idle();
        tick();
        tick();
    endtask

    task automatic capture(input logic [1:0] cls, input logic [AW-1:0] rd, input logic [DW-1:0] data);
        ex_valid = 1'b1; ex_class = cls; ex_rd = rd; ex_scalar = data;
        tick();
        ex_valid = 1'b0;
    endtask

    task automatic decode(input logic [1:0] cls, input logic [AW-1:0] ra, input logic [AW-1:0] rb);
        dec_valid = 1'b1; dec_class = cls; dec_ra = ra; dec_rb = rb;
        #1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        set_idle();
        tick();
        tick();
        checks++; if (s_mux_A !== 1'b0 || s_mux_B !== 1'b0) begin errors++; $display("FAIL rst_smux: got A=%b B=%b want 0 0", s_mux_A, s_mux_B); end
        checks++; if (wb_valid !== 1'b0 || wb_rd !== '0 || wb_class !== 2'b00) begin errors++; $display("FAIL rst_wb: got v=%b rd=%h cls=%b want 0 0 0", wb_valid, wb_rd, wb_class); end
        #3 rst_n = 1'b1;
        tick();
        checks++; if (A_ua_int !== '0 || B_ua_fixed !== '0 || A_ua_vector !== '0) begin errors++; $display("FAIL rst_ua: got A=%h Bf=%h want 0", A_ua_int, B_ua_fixed); end
        checks++; if (wb_scalar !== '0 || wb_vector !== '0 || wb_valid !== 1'b0) begin errors++; $display("FAIL rst_wbdata: got %h v=%b want 0", wb_scalar, wb_valid); end
    endtask

    task automatic test_int_forward();
        drain();
        capture(2'b00, 4'd3, 16'h0005);
        decode(2'b00, 4'd3, 4'd4);
        checks++; if (s_mux_A !== 1'b1 || A_ua_int !== 16'h0005 || A_ua_fixed !== 16'h0005) begin errors++; $display("FAIL int_s1_A: got sel=%b %h/%h want 1 0005", s_mux_A, A_ua_int, A_ua_fixed); end
        checks++; if (s_mux_B !== 1'b0 || B_ua_int !== 16'h0000) begin errors++; $display("FAIL int_s1_B: got sel=%b %h want 0 0000", s_mux_B, B_ua_int); end
        checks++; if (wb_valid !== 1'b0) begin errors++; $display("FAIL int_wb_early: got %b want 0", wb_valid); end
        tick();
        checks++; if (s_mux_A !== 1'b1 || A_ua_int !== 16'h0005) begin errors++; $display("FAIL int_s2_A: got sel=%b %h want 1 0005", s_mux_A, A_ua_int); end
        checks++; if (wb_valid !== 1'b1 || wb_rd !== 4'd3 || wb_class !== 2'b00 || wb_scalar !== 16'h0005) begin errors++; $display("FAIL int_wb: got v=%b rd=%h cls=%b d=%h want 1 3 00 0005", wb_valid, wb_rd, wb_class, wb_scalar); end
        tick();
        checks++; if (s_mux_A !== 1'b0 || A_ua_int !== 16'h0000 || wb_valid !== 1'b0) begin errors++; $display("FAIL int_gone: got sel=%b %h wb=%b want 0 0000 0", s_mux_A, A_ua_int, wb_valid); end
    endtask

    task automatic test_priority();
        drain();
        capture(2'b00, 4'd2, 16'h1111);
        capture(2'b00, 4'd2, 16'h2222);
        decode(2'b00, 4'd2, 4'd5);
        checks++; if (s_mux_A !== 1'b1 || A_ua_int !== 16'h2222) begin errors++; $display("FAIL prio_s1: got sel=%b %h want 1 2222", s_mux_A, A_ua_int); end
        checks++; if (wb_valid !== 1'b1 || wb_scalar !== 16'h1111) begin errors++; $display("FAIL prio_wb_old: got v=%b %h want 1 1111", wb_valid, wb_scalar); end
        tick();
        checks++; if (A_ua_int !== 16'h2222 || wb_scalar !== 16'h2222) begin errors++; $display("FAIL prio_s2: got A=%h wb=%h want 2222 2222", A_ua_int, wb_scalar); end
    endtask

    task automatic test_filter();
        drain();
        capture(2'b01, 4'd5, 16'h0505);
        decode(2'b00, 4'd5, 4'd5);
        checks++; if (s_mux_A !== 1'b0 || s_mux_B !== 1'b0 || A_ua_fixed !== '0) begin errors++; $display("FAIL cls_mismatch: got A=%b B=%b d=%h want 0 0 0000", s_mux_A, s_mux_B, A_ua_fixed); end
        decode(2'b01, 4'd5, 4'd5);
        checks++; if (s_mux_A !== 1'b1 || A_ua_fixed !== 16'h0505 || B_ua_fixed !== 16'h0505) begin errors++; $display("FAIL cls_fixed: got sel=%b %h/%h want 1 0505", s_mux_A, A_ua_fixed, B_ua_fixed); end
        dec_valid = 1'b0;
        #1;
        checks++; if (s_mux_A !== 1'b0 || s_mux_B !== 1'b0) begin errors++; $display("FAIL dec_invalid: got A=%b B=%b want 0 0", s_mux_A, s_mux_B); end
        capture(2'b00, 4'd0, 16'h0F0F);
        decode(2'b00, 4'd0, 4'd0);
        checks++; if (s_mux_A !== 1'b0 || s_mux_B !== 1'b0 || A_ua_int !== '0) begin errors++; $display("FAIL r0: got A=%b B=%b d=%h want 0 0 0000", s_mux_A, s_mux_B, A_ua_int); end
        for (int i = 0; i < int'(VL); i++) ex_vector[i*DW +: DW] = DW'(i + 1);
        capture(2'b10, 4'd1, 16'h0000);
        decode(2'b10, 4'd9, 4'd1);
        checks++; if (s_mux_B !== 1'b1 || s_mux_A !== 1'b0) begin errors++; $display("FAIL vec_sel: got A=%b B=%b want 0 1", s_mux_A, s_mux_B); end
        checks++; if (B_ua_vector[15*DW +: DW] !== 16'd16 || B_ua_vector[0 +: DW] !== 16'd1 || A_ua_vector !== '0) begin errors++; $display("FAIL vec_data: got l15=%h l0=%h want 0010 0001", B_ua_vector[15*DW +: DW], B_ua_vector[0 +: DW]); end
        capture(2'b11, 4'd1, 16'h3333);
        decode(2'b11, 4'd1, 4'd1);
        checks++; if (s_mux_A !== 1'b0 || s_mux_B !== 1'b0) begin errors++; $display("FAIL cls_none: got A=%b B=%b want 0 0", s_mux_A, s_mux_B); end
        decode(2'b10, 4'd1, 4'd1);
        checks++; if (s_mux_B !== 1'b1 || B_ua_vector[15*DW +: DW] !== 16'd16) begin errors++; $display("FAIL vec_s2: got sel=%b l15=%h want 1 0010", s_mux_B, B_ua_vector[15*DW +: DW]); end
    endtask

    task automatic test_both_operands();
        drain();
        capture(2'b00, 4'd4, 16'h4444);
        decode(2'b00, 4'd4, 4'd4);
        checks++; if (s_mux_A !== 1'b1 || s_mux_B !== 1'b1 || A_ua_int !== 16'h4444 || B_ua_int !== 16'h4444) begin errors++; $display("FAIL both: got A=%b/%h B=%b/%h want 1/4444 1/4444", s_mux_A, A_ua_int, s_mux_B, B_ua_int); end
    endtask

    task automatic test_stall();
        drain();
        capture(2'b00, 4'd7, 16'h0077);
        stall = 1'b1;
        ex_valid = 1'b1; ex_class = 2'b00; ex_rd = 4'd7; ex_scalar = 16'h0999;
        decode(2'b00, 4'd7, 4'd8);
        for (int c = 0; c < 3; c++) begin
            tick();
            checks++; if (s_mux_A !== 1'b1 || A_ua_int !== 16'h0077 || wb_valid !== 1'b0) begin errors++; $display("FAIL stall_hold%0d: got sel=%b %h wb=%b want 1 0077 0", c, s_mux_A, A_ua_int, wb_valid); end
        end
        stall = 1'b0;
        ex_valid = 1'b0;
        #1;
        checks++; if (wb_valid !== 1'b0) begin errors++; $display("FAIL stall_rel_wb: got %b want 0", wb_valid); end
        tick();
        checks++; if (wb_valid !== 1'b1 || wb_rd !== 4'd7 || A_ua_int !== 16'h0077) begin errors++; $display("FAIL stall_s2: got v=%b rd=%h A=%h want 1 7 0077", wb_valid, wb_rd, A_ua_int); end
        stall = 1'b1;
        #1;
        checks++; if (wb_valid !== 1'b0) begin errors++; $display("FAIL stall_wb_gate: got %b want 0", wb_valid); end
        tick();
        checks++; if (wb_valid !== 1'b0 || s_mux_A !== 1'b1 || A_ua_int !== 16'h0077) begin errors++; $display("FAIL stall_s2_hold: got v=%b sel=%b %h want 0 1 0077", wb_valid, s_mux_A, A_ua_int); end
        stall = 1'b0;
        #1;
        checks++; if (wb_valid !== 1'b1) begin errors++; $display("FAIL stall_wb_once: got %b want 1", wb_valid); end
        tick();
        checks++; if (wb_valid !== 1'b0 || s_mux_A !== 1'b0) begin errors++; $display("FAIL stall_drained: got v=%b sel=%b want 0 0", wb_valid, s_mux_A); end
    endtask

    task automatic test_flush();
        drain();
        flush = 1'b1;
        capture(2'b00, 4'd6, 16'h0066);
        flush = 1'b0;
        decode(2'b00, 4'd6, 4'd6);
        checks++; if (s_mux_A !== 1'b0 || A_ua_int !== 16'h0000) begin errors++; $display("FAIL flush_s1: got sel=%b %h want 0 0000", s_mux_A, A_ua_int); end
        tick();
        checks++; if (s_mux_A !== 1'b0 || wb_valid !== 1'b0) begin errors++; $display("FAIL flush_s2: got sel=%b wb=%b want 0 0", s_mux_A, wb_valid); end
        capture(2'b00, 4'd8, 16'h0088);
        decode(2'b00, 4'd8, 4'd1);
        checks++; if (s_mux_A !== 1'b1 || A_ua_int !== 16'h0088) begin errors++; $display("FAIL flush_pre: got sel=%b %h want 1 0088", s_mux_A, A_ua_int); end
        stall = 1'b1; flush = 1'b1;
        tick();
        checks++; if (s_mux_A !== 1'b0) begin errors++; $display("FAIL flush_stall: got sel=%b want 0", s_mux_A); end
        stall = 1'b0; flush = 1'b0;
        tick();
        checks++; if (wb_valid !== 1'b0 || s_mux_A !== 1'b0) begin errors++; $display("FAIL flush_stall_wb: got v=%b sel=%b want 0 0", wb_valid, s_mux_A); end
    endtask

    task automatic test_reset_midstream();
        drain();
        capture(2'b00, 4'd9, 16'h0099);
        capture(2'b00, 4'd9, 16'h0199);
        decode(2'b00, 4'd9, 4'd9);
        checks++; if (s_mux_A !== 1'b1 || wb_valid !== 1'b1 || A_ua_int !== 16'h0199) begin errors++; $display("FAIL mid_pre: got sel=%b wb=%b %h want 1 1 0199", s_mux_A, wb_valid, A_ua_int); end
        #2 rst_n = 1'b0;
        #1;
        checks++; if (s_mux_A !== 1'b0 || s_mux_B !== 1'b0 || wb_valid !== 1'b0 || wb_rd !== '0) begin errors++; $display("FAIL mid_rst: got A=%b B=%b wb=%b rd=%h want 0 0 0 0", s_mux_A, s_mux_B, wb_valid, wb_rd); end
        #1 rst_n = 1'b1;
        tick();
        checks++; if (s_mux_A !== 1'b0 || wb_valid !== 1'b0 || A_ua_int !== '0) begin errors++; $display("FAIL mid_resume: got sel=%b wb=%b %h want 0 0 0000", s_mux_A, wb_valid, A_ua_int); end
    endtask

    initial begin
        test_reset();
        test_int_forward();
        test_priority();
        test_filter();
        test_both_operands();
        test_stall();
        test_flush();
        test_reset_midstream();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/ex_forward_unit.md
# ex_forward_unit

Two-stage result pipeline and bypass unit sitting directly after the execution stage. It captures each execution result (scalar integer, scalar fixed-point, or 16-lane vector) with its destination register tag and carries it through two stages (EX/MEM, MEM/WB). Each cycle it compares the decode stage's source tags against both stages and drives the bypass operands and select lines (`s_mux_A`, `s_mux_B`) back into the execution stage's operand muxes. The stage-2 contents are also presented as the register-file write-back port.

## Interface
Parameters:
- DATA_WIDTH, 16, element width of scalar and vector lanes
- VECTOR_LENGTH, 16, lanes per vector
- REG_ADDR_WIDTH, 4, register tag width

Ports:
- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous active-low reset
- stall  in  1  freeze both stages
- flush  in  1  squash the EX result being captured this cycle
- ex_valid  in  1  EX result present
- ex_class  in  2  00 int, 01 fixed, 10 vector (11 = no write)
- ex_rd  in  REG_ADDR_WIDTH  destination tag
- ex_scalar  in  DATA_WIDTH  Out_int or Out_fixed per ex_class
- ex_vector  in  DATA_WIDTH×VECTOR_LENGTH  Out_vector
- dec_valid  in  1  decode holds a real instruction
- dec_class  in  2  operand class of the decoded instruction
- dec_ra, dec_rb  in  REG_ADDR_WIDTH  source tags
- A_ua_int, A_ua_fixed, B_ua_int, B_ua_fixed  out  DATA_WIDTH  forwarded scalars
- A_ua_vector, B_ua_vector  out  DATA_WIDTH×VECTOR_LENGTH  forwarded vectors
- s_mux_A, s_mux_B  out  1  1 = execution stage uses the forwarded operand
- wb_valid  out  1; wb_class  out  2; wb_rd  out  REG_ADDR_WIDTH; wb_scalar  out  DATA_WIDTH; wb_vector  out  DATA_WIDTH×VECTOR_LENGTH

## Operation
- Stage 1 (S1) and stage 2 (S2) each hold valid, class, rd, scalar, vector.
- Each non-stalled edge: S2 ← S1; S1 ← EX inputs. S1.valid ← ex_valid & (ex_class≠11) & ~flush.
- stall=1: S1 and S2 hold. flush=1 with stall=1: S1.valid ← 0, everything else holds. Flush beats stall for S1.valid only.
- Hit on stage X for operand A: X.valid & dec_valid & X.class==dec_class & X.rd==dec_ra & ~(dec_class==00 & dec_ra==0). Operand B is the same with dec_rb. Integer r0 is never forwarded.
- Priority: an S1 hit beats an S2 hit (S1 is the younger result).
- s_mux_A = hit_S1_A | hit_S2_A. s_mux_B is the same for B.
- The forwarded scalar comes from the winning stage and drives both the _int and _fixed outputs. The forwarded vector comes from the winning stage's vector.
- On no hit: the forwarded data outputs are 0 and s_mux is 0.
- Write-back port: wb_* = S2 fields, gated by S2.valid. wb_valid is also 0 while stall=1, so a stalled write is retired exactly once.
- All forwarding and write-back outputs are combinational from the stage registers and the decode inputs. There are no combinational paths from the ex_* inputs.

## Timing
- Reset (rst_n low, asynchronous): all S1/S2 fields 0. Consequently s_mux_A = s_mux_B = 0, all ua outputs 0, and wb_valid = 0, wb_class = 0, wb_rd = 0, wb data 0.
- A result captured at edge N is forwardable in cycle N (after the edge) via S1, and in cycle N+1 via S2. It appears on wb_* in cycle N+1.
- Back-to-back writes to the same tag: the later write wins via S1 priority. Once the later write reaches S2, the older one has already left the pipeline.
- A single S1 entry may hit both A and B (dec_ra==dec_rb). Both selects assert.
- A reset deassertion mid-stream resumes from empty stages. No partial state survives.

## Test plan
- Reset: hold rst_n=0, then release → s_mux_A=s_mux_B=0, wb_valid=0, all ua=0.
- Int forward: at edge 1, ex int rd=3 data=0x0005. Decode int ra=3 rb=4 → cycle 1 s_mux_A=1, A_ua_int=0x0005, s_mux_B=0. Cycle 2: S2 hit still forwards 0x0005, wb_valid=1, wb_rd=3.
- Priority: at edge 1, rd=2 data 0x1111. At edge 2, rd=2 data 0x2222. Decode ra=2 in cycle 2 → A_ua_int=0x2222.
- Class and r0 filtering:
  - Fixed result with rd=5, decode int ra=5 → s_mux_A=0.
  - Int result with rd=0, decode int ra=0 → s_mux_A=0.
  - Vector rd=1 with lanes i=i+1, decode vector rb=1 → s_mux_B=1, B_ua_vector lane 15=16.
- Stall and flush:
  - Capture rd=7, then stall=1 for 3 cycles → S1 holds, forwarding persists, wb_valid=0 throughout.
  - flush=1 on a capture edge → that result is never forwarded and never written back.
